fifo_256i_16o_unpack: RTL and testbench

//  Single-clock down-converting FIFO: accepts IN_WIDTH-bit words, emits OUT_WIDTH-bit lanes.

---
 rtl/fifo_256i_16o_unpack_if.sv | 30 +++
 rtl/fifo_256i_16o_unpack.sv | 121 ++++++++++++
 tb/tb_fifo_256i_16o_unpack.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_256i_16o_unpack_if.sv
// rtl/fifo_256i_16o_unpack_if.sv - write/read port bundle of the wide-in, narrow-out unpacking FIFO
interface fifo_256i_16o_unpack_if #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 16,
  parameter int ENTRY_NUM = 4
);
  localparam int LANES = IN_WIDTH / OUT_WIDTH;
  localparam int EW    = $clog2(ENTRY_NUM);
  localparam int RW    = $clog2(ENTRY_NUM * LANES);

  logic [IN_WIDTH-1:0]  wr_data;
  logic                 wr_en;
  logic                 wr_full;
  logic [EW:0]          wr_water_level;
  logic                 rd_en;
  logic [OUT_WIDTH-1:0] rd_data;
  logic                 rd_empty;
  logic [RW:0]          rd_water_level;
  logic                 almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, rd_data, rd_empty, rd_water_level, almost_empty
  );
endinterface

// File: rtl/fifo_256i_16o_unpack.sv
// rtl/fifo_256i_16o_unpack.sv - single-clock FIFO storing wide words and popping them one narrow lane at a time
// Optional UNPACK_MSB_FIRST_EN: emit the most significant lane of each stored word first.
module fifo_256i_16o_unpack #(
  parameter int IN_WIDTH         = 256,
  parameter int OUT_WIDTH        = 16,
  parameter int ENTRY_NUM        = 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_256i_16o_unpack_if.slave   bus
);
  localparam int LANES = IN_WIDTH / OUT_WIDTH;
  localparam int EW    = $clog2(ENTRY_NUM);
  localparam int RW    = $clog2(ENTRY_NUM * LANES);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IN_WIDTH-1:0]  mem_q [ENTRY_NUM];
  logic [EW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [EW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        lane_ptr_q, lane_ptr_d;
  logic [EW:0]          count_q, count_d;
  logic [OUT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 almost_empty_q, almost_empty_d;
  logic [RW:0]          rd_level_q, rd_level_d;

  logic                 wr_acc;
  logic                 rd_acc;
  logic                 last_lane;
  logic                 entry_freed;
  logic [LW-1:0]        lane_sel;
  logic [IN_WIDTH-1:0]  head_word;
  logic [OUT_WIDTH-1:0] lane_data;

  // Acceptance uses only registered flags, so there is no path from wr_en/rd_en to the flags.
  assign wr_acc      = bus.wr_en & ~full_q;
  assign rd_acc      = bus.rd_en & ~empty_q;
  assign last_lane   = (lane_ptr_q == LW'(LANES - 1));
  assign entry_freed = rd_acc & last_lane;
  assign head_word   = mem_q[rd_ptr_q];

`ifdef UNPACK_MSB_FIRST_EN
  assign lane_sel = LW'(LANES - 1) - lane_ptr_q;
`else
  assign lane_sel = lane_ptr_q;
`endif

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_sel == LW'(i)) begin
        lane_data = head_word[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_ptr_d = lane_ptr_q;
    rd_data_d  = rd_data_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_data_d  = lane_data;
      lane_ptr_d = last_lane ? '0 : lane_ptr_q + 1'b1;
    end
    if (entry_freed) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Next-state flags and levels, registered alongside the pointers.
  always_comb begin
    count_d        = count_q + (EW+1)'(wr_acc) - (EW+1)'(entry_freed);
    full_d         = (count_d == (EW+1)'(ENTRY_NUM));
    empty_d        = (count_d == '0);
    rd_level_d     = (RW+1)'(count_d) * (RW+1)'(LANES) - (RW+1)'(lane_ptr_d);
    almost_empty_d = (int'(rd_level_d) <= ALMOST_EMPTY_NUM);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      lane_ptr_q     <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_level_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      lane_ptr_q     <= lane_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      rd_level_q     <= rd_level_d;
    end
  end

  assign bus.wr_full        = full_q;
  assign bus.wr_water_level = count_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_empty       = empty_q;
  assign bus.rd_water_level = rd_level_q;
  assign bus.almost_empty   = almost_empty_q;
endmodule

// File: tb/tb_fifo_256i_16o_unpack.sv
// tb/tb_fifo_256i_16o_unpack.sv - randomized and directed bench for fifo_256i_16o_unpack against a word-queue model
module tb_fifo_256i_16o_unpack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_256i_16o_unpack_if #(.IN_WIDTH(256), .OUT_WIDTH(16), .ENTRY_NUM(4)) bus ();

  fifo_256i_16o_unpack #(
    .IN_WIDTH(256), .OUT_WIDTH(16), .ENTRY_NUM(4), .ALMOST_EMPTY_NUM(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n_rd   = 0;

  // Model: a queue of whole stored words plus the index of the next lane in the head word.
  logic [255:0] m_words[$];
  int           m_lane = 0;
  logic [15:0]  m_rd   = '0;

  function automatic logic [15:0] lane_of(input logic [255:0] w, input int i);
`ifdef UNPACK_MSB_FIRST_EN
    return w[255 - 16*i -: 16];
`else
    return w[16*i +: 16];
`endif
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
    return w;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int lvl;
    lvl = m_words.size() * 16 - m_lane;
    check("rd_data",        256'(bus.rd_data),        256'(m_rd));
    check("rd_empty",       256'(bus.rd_empty),       256'(m_words.size() == 0));
    check("wr_full",        256'(bus.wr_full),        256'(m_words.size() == 4));
    check("wr_water_level", 256'(bus.wr_water_level), 256'(m_words.size()));
    check("rd_water_level", 256'(bus.rd_water_level), 256'(lvl));
    check("almost_empty",   256'(bus.almost_empty),   256'(lvl <= 4));
  endtask

  task automatic step(input logic we, input logic [255:0] wd, input logic re);
    bit wa, ra;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    wa = we && (m_words.size() < 4);
    ra = re && (m_words.size() > 0);
    @(posedge clk);
    if (ra) begin
      m_rd = lane_of(m_words[0], m_lane);
      m_lane++;
      if (m_lane == 16) begin
        void'(m_words.pop_front());
        m_lane = 0;
      end
      n_rd++;
    end
    if (wa) begin
      m_words.push_back(wd);
      n_wr++;
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_model();
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (cycles) @(posedge clk);
    m_words.delete();
    m_lane = 0;
    m_rd   = '0;
    #1;
    rst = 1'b0;
    check_model();
  endtask

  task automatic drain();
    int guard = 0;
    while (m_words.size() > 0 && guard < 200) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    check("drain_empty", 256'(bus.rd_empty), 256'(1));
  endtask

  initial begin
    logic [255:0] w;
    logic [15:0]  held;
    int           guard;

    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // Reset state
    do_reset(3);
    check("reset_empty",  256'(bus.rd_empty),       256'(1));
    check("reset_full",   256'(bus.wr_full),        256'(0));
    check("reset_aempty", 256'(bus.almost_empty),   256'(1));
    check("reset_rdata",  256'(bus.rd_data),        256'(0));
    check("reset_rlvl",   256'(bus.rd_water_level), 256'(0));
    check("reset_wlvl",   256'(bus.wr_water_level), 256'(0));

    // Lane order
    for (int i = 0; i < 16; i++) w[16*i +: 16] = 16'(i);
    step(1'b1, w, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
      check("order_lane", 256'(bus.rd_data), 256'(15 - i));
`else
      check("order_lane", 256'(bus.rd_data), 256'(i));
`endif
    end
    check("order_empty", 256'(bus.rd_empty), 256'(1));

    // Full and dropped fifth write
    for (int k = 0; k < 5; k++) begin
      step(1'b1, rand_word(), 1'b0);
      if (k == 3) check("full_after4", 256'(bus.wr_full), 256'(1));
    end
    check("full_rlvl", 256'(bus.rd_water_level), 256'(64));
    drain();

    // Full with last-lane pop in the same cycle
    for (int k = 0; k < 4; k++) step(1'b1, rand_word(), 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, '0, 1'b1);
    step(1'b1, rand_word(), 1'b1);
    check("fullpop_wlvl", 256'(bus.wr_water_level), 256'(3));
    check("fullpop_rlvl", 256'(bus.rd_water_level), 256'(48));
    drain();

    // Empty edges
    held = m_rd;
    step(1'b0, '0, 1'b1);
    check("empty_rd_hold", 256'(bus.rd_data), 256'(held));
    step(1'b1, rand_word(), 1'b1);
    check("empty_wr_notempty", 256'(bus.rd_empty),       256'(0));
    check("empty_wr_rlvl",     256'(bus.rd_water_level), 256'(16));
    check("empty_wr_aempty",   256'(bus.almost_empty),   256'(0));
    for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1);
    check("pop12_rlvl",   256'(bus.rd_water_level), 256'(4));
    check("pop12_aempty", 256'(bus.almost_empty),   256'(1));
    drain();

    // Random interleave: 12 writes and 192 reads so the pointers wrap
    n_wr  = 0;
    n_rd  = 0;
    guard = 0;
    while ((n_wr < 12 || n_rd < 192) && guard < 3000) begin
      step(n_wr < 12 ? 1'($urandom % 2) : 1'b0, rand_word(), 1'($urandom % 2));
      guard++;
    end
    check("wrap_done", 256'(n_wr == 12 && n_rd == 192), 256'(1));
    check("wrap_empty", 256'(bus.rd_empty), 256'(1));

    // Mid-stream reset, then only new data may come out
    for (int k = 0; k < 40; k++) step(1'($urandom % 2), rand_word(), 1'($urandom % 3 == 0));
    do_reset(1);
    check("midrst_empty", 256'(bus.rd_empty),       256'(1));
    check("midrst_rlvl",  256'(bus.rd_water_level), 256'(0));
    check("midrst_wlvl",  256'(bus.wr_water_level), 256'(0));
    for (int k = 0; k < 150; k++) step(1'($urandom % 2), rand_word(), 1'($urandom % 4 != 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
